// File: rtl/pattern_pkg.sv
// pattern_pkg
//   Shared definitions for the pattern sequencer:
//   - mode_t        : pattern mode encoding (one-hot ring / Johnson)
//   - DEFAULT_CHARS : power-on character table contents ("NickWantz")
//   - SPACE_CHAR    : fill value for table entries beyond the default text
//   - default_char  : reset value of a table entry by index
//   - pos_to_pattern: stage pattern for a given position and mode
package pattern_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_t;

    // Widest stage count pos_to_pattern can describe.
    localparam int MAX_N = 64;

    localparam int DEFAULT_COUNT = 9;
    localparam logic [6:0] DEFAULT_CHARS [0:DEFAULT_COUNT-1] = '{
        7'h4E, 7'h69, 7'h63, 7'h6B, 7'h57, 7'h61, 7'h6E, 7'h74, 7'h7A
    };
    localparam logic [6:0] SPACE_CHAR = 7'h20;

    function automatic logic [6:0] default_char(int idx);
        logic [6:0] ch;
        ch = SPACE_CHAR;
        if (idx < DEFAULT_COUNT) begin
            ch = DEFAULT_CHARS[idx];
        end
        return ch;
    endfunction

    // Bit i of the result is stage Q[i]; only bits 0..n-1 are meaningful.
    // Johnson positions 0..n fill ones from stage 0, positions n+1..2n-1
    // drain them again from stage 0.
    function automatic logic [0:MAX_N-1] pos_to_pattern(int pos, mode_t mode, int n);
        logic [0:MAX_N-1] pat;
        pat = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                if (mode == MODE_RING) begin
                    pat[i] = (i == pos);
                end else if (pos <= n) begin
                    pat[i] = (i < pos);
                end else begin
                    pat[i] = (i >= pos - n);
                end
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if
//   Control, table-write and status bundle of the pattern sequencer.
//   master : drives EN/DIR/MODE/LOAD/LOAD_POS/WE/WADDR/WDATA, observes Q/POS/C/WRAP
//   slave  : the sequencer itself
interface pattern_sequencer_if #(
    parameter int N  = 9,
    parameter int CW = 7
);
    localparam int PW = $clog2(2 * N);

    logic          EN;
    logic          DIR;
    logic          MODE;
    logic          LOAD;
    logic [PW-1:0] LOAD_POS;
    logic          WE;
    logic [PW-1:0] WADDR;
    logic [CW-1:0] WDATA;
    logic [0:N-1]  Q;
    logic [PW-1:0] POS;
    logic [0:CW-1] C;
    logic          WRAP;

    modport master (
        output EN, DIR, MODE, LOAD, LOAD_POS, WE, WADDR, WDATA,
        input  Q, POS, C, WRAP
    );

    modport slave (
        input  EN, DIR, MODE, LOAD, LOAD_POS, WE, WADDR, WDATA,
        output Q, POS, C, WRAP
    );

endinterface

// File: rtl/pattern_sequencer_char_table.sv
// char_table
//   N x CW character register file. Reset restores the default text.
//   CLK, RST      : clock, asynchronous active-high reset
//   WE/WADDR/WDATA: write port, addresses >= N are dropped
//   RADDR/RDATA   : combinational read port, RADDR always < N
module char_table
    import pattern_pkg::*;
#(
    parameter int  N  = 9,
    parameter int  CW = 7,
    localparam int PW = $clog2(2 * N),
    localparam int AW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WE,
    input  logic [PW-1:0] WADDR,
    input  logic [CW-1:0] WDATA,
    input  logic [PW-1:0] RADDR,
    output logic [CW-1:0] RDATA
);

    logic [CW-1:0] mem [0:N-1];

    // NOTE: this table is reset entry by entry because the default text must
    // reappear on reset; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= CW'(default_char(i));
            end
        end else if (WE && (int'(WADDR) < N)) begin
            mem[WADDR[AW-1:0]] <= WDATA;
        end
    end

    assign RDATA = mem[RADDR[AW-1:0]];

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   N-stage shift pattern (one-hot ring or Johnson) tracked as a position
//   index, with a writable character table addressed by that position.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : control inputs EN/DIR/MODE/LOAD/LOAD_POS, table write
//              WE/WADDR/WDATA, outputs Q/POS (registered), C (combinational
//              from registered state), WRAP (registered one-cycle pulse)
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int  N  = 9,
    parameter int  CW = 7,
    localparam int PW = $clog2(2 * N)
) (
    input logic                CLK,
    input logic                RST,
    pattern_sequencer_if.slave bus
);

    localparam logic [0:N-1] RING_START = {1'b1, {(N-1){1'b0}}};

    mode_t         mode_q, mode_n;
    logic [PW-1:0] pos_q, pos_n;
    logic [0:N-1]  q_q, q_n;
    logic          wrap_q, wrap_n;
    int            lim;
    logic [PW-1:0] rd_addr;
    logic [CW-1:0] rd_data;

    // Priority: mode change > load > step > hold. Q is derived from the
    // next position so it is registered together with POS.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave
        // one unassigned and infer a latch.
        mode_n = mode_q;
        pos_n  = pos_q;
        wrap_n = 1'b0;
        lim    = (mode_q == MODE_JOHNSON) ? 2 * N : N;

        if (mode_t'(bus.MODE) != mode_q) begin
            mode_n = mode_t'(bus.MODE);
            pos_n  = '0;
        end else if (bus.LOAD) begin
            pos_n = (int'(bus.LOAD_POS) < lim) ? bus.LOAD_POS : '0;
        end else if (bus.EN) begin
            if (!bus.DIR) begin
                if (int'(pos_q) == lim - 1) begin
                    pos_n  = '0;
                    wrap_n = 1'b1;
                end else begin
                    pos_n = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    pos_n  = PW'(lim - 1);
                    wrap_n = 1'b1;
                end else begin
                    pos_n = pos_q - PW'(1);
                end
            end
        end

        // Stage 0 sits in the MSB of the function result; shift it down to
        // the N-bit window.
        q_n = N'(pos_to_pattern(int'(pos_n), mode_n, N) >> (MAX_N - N));
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= MODE_RING;
            pos_q  <= '0;
            q_q    <= RING_START;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_n;
            pos_q  <= pos_n;
            q_q    <= q_n;
            wrap_q <= wrap_n;
        end
    end

    // Johnson positions N..2N-1 reuse the table entries of 0..N-1.
    assign rd_addr = (mode_q == MODE_JOHNSON && int'(pos_q) >= N) ? pos_q - PW'(N) : pos_q;

    char_table #(
        .N (N),
        .CW(CW)
    ) u_char_table (
        .CLK  (CLK),
        .RST  (RST),
        .WE   (bus.WE),
        .WADDR(bus.WADDR),
        .WDATA(bus.WDATA),
        .RADDR(rd_addr),
        .RDATA(rd_data)
    );

    assign bus.Q    = q_q;
    assign bus.POS  = pos_q;
    assign bus.C    = rd_data;
    assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer
//   Directed and randomized stimulus for pattern_sequencer. Each issued cycle
//   pushes the expected post-edge state (from a position/table model) into a
//   scoreboard queue; an independent monitor pops and compares every cycle.
module tb_pattern_sequencer;

    localparam int N  = 9;
    localparam int CW = 7;
    localparam int PW = $clog2(2 * N);

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    pattern_sequencer_if #(.N(N), .CW(CW)) bus ();

    pattern_sequencer #(.N(N), .CW(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        logic [0:N-1] q;
        int           pos;
        int           c;
        bit           wrap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: position, mode, wrap flag and character table.
    int    m_pos;
    int    m_mode;
    bit    m_wrap;
    int    m_tbl[N];
    string def_text = "NickWantz";

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:N-1] model_q(int pos, int mode);
        logic [0:N-1] r;
        for (int i = 0; i < N; i++) begin
            if (mode == 0)      r[i] = (i == pos);
            else if (pos <= N)  r[i] = (i < pos);
            else                r[i] = (i >= pos - N);
        end
        return r;
    endfunction

    function automatic int model_c();
        return m_tbl[(m_mode != 0) ? (m_pos % N) : m_pos];
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_mode = 0;
        m_wrap = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_tbl[i] = (i < def_text.len()) ? int'(def_text[i]) : 32'h20;
        end
    endtask

    task automatic drive_idle();
        bus.EN       = 1'b0;
        bus.DIR      = 1'b0;
        bus.MODE     = m_mode[0];
        bus.LOAD     = 1'b0;
        bus.LOAD_POS = '0;
        bus.WE       = 1'b0;
        bus.WADDR    = '0;
        bus.WDATA    = '0;
    endtask

    // One clocked cycle of stimulus; the model result is queued for the monitor.
    task automatic step(bit en, bit dir, bit mode, bit load, int lpos,
                        bit we, int waddr, int wdata);
        exp_t e;
        int   lim;
        @(negedge CLK);
        bus.EN       = en;
        bus.DIR      = dir;
        bus.MODE     = mode;
        bus.LOAD     = load;
        bus.LOAD_POS = PW'(lpos);
        bus.WE       = we;
        bus.WADDR    = PW'(waddr);
        bus.WDATA    = CW'(wdata);

        lim    = (m_mode != 0) ? 2 * N : N;
        m_wrap = 1'b0;
        if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_pos  = 0;
        end else if (load) begin
            m_pos = (lpos < lim) ? lpos : 0;
        end else if (en) begin
            if (!dir) begin
                m_wrap = (m_pos == lim - 1);
                m_pos  = (m_pos + 1) % lim;
            end else begin
                m_wrap = (m_pos == 0);
                m_pos  = (m_pos + lim - 1) % lim;
            end
        end
        if (we && waddr < N) m_tbl[waddr] = wdata;

        e.q    = model_q(m_pos, m_mode);
        e.pos  = m_pos;
        e.c    = model_c();
        e.wrap = m_wrap;
        sb.push_back(e);

        @(posedge CLK);
        #1;
        drive_idle();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_Q"},    64'(bus.Q),    64'(model_q(0, 0)));
        check({tag, "_POS"},  64'(bus.POS),  64'd0);
        check({tag, "_C"},    64'(bus.C),    64'(m_tbl[0]));
        check({tag, "_WRAP"}, 64'(bus.WRAP), 64'd0);
    endtask

    // Monitor: every cycle with a queued expectation is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("Q",    64'(bus.Q),    64'(e.q));
                check("POS",  64'(bus.POS),  64'(e.pos));
                check("C",    64'(bus.C),    64'(e.c));
                check("WRAP", 64'(bus.WRAP), 64'(e.wrap));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cur;
        model_reset();
        drive_idle();
        RST = 1'b1;
        #3;
        check_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Ring forward over a full lap: wrap only on 8 -> 0.
        for (int i = 0; i < N; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        // Ring reverse 0 -> 8, then forward 8 -> 0.
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Mode change to Johnson (EN ignored), then a full 2N lap.
        step(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * N; i++) step(1, 0, 1, 0, 0, 0, 0, 0);
        // Back to ring, load has priority over EN, out-of-range load -> 0.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 1, 12, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0, 0);
        // Write the displayed entry, then an ignored out-of-range write.
        step(0, 0, 0, 0, 0, 1, 3, 'h21);
        step(0, 0, 0, 0, 0, 1, 9, 'h55);
        // Walk to 6, writing entry 6 on the same edge as the step into it.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 6, 'h3F);

        // Asynchronous reset mid-cycle.
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge CLK);
        RST = 1'b0;

        // Written entries reverted to defaults.
        step(0, 0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 6, 0, 0, 0);
        // Johnson reverse wrap 0 -> 2N-1.
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cur = m_mode[0];
            if ($urandom_range(0, 15) == 0) cur = ~cur;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), cur,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                 int'($urandom_range(32'h21, 32'h7E)));
        end

        @(posedge CLK);
        #2;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Parametrised successor to the fixed 9-stage one-hot ring and character coder.
- Holds an N-stage shift pattern that runs in one of two modes: one-hot ring or Johnson (twisted ring).
- Adds run enable, direction, positional load, a wrap pulse and a writable character table.
- Sits between the clock source and the character display/monitor path; C is the 7-bit ASCII code for the current position.

Parameters:
- N, 9, number of stages (N >= 2)
- CW, 7, character code width
- PW, $clog2(2*N), position register width (derived; not overridden)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- EN  input  1  advance one step per CLK edge when 1
- DIR  input  1  0 = forward (Q[i] <= Q[i-1]), 1 = reverse (Q[i] <= Q[i+1])
- MODE  input  1  0 = one-hot ring (N states), 1 = Johnson (2N states)
- LOAD  input  1  synchronous load of LOAD_POS
- LOAD_POS  input  PW  target position for LOAD
- WE  input  1  character table write strobe
- WADDR  input  PW  table address
- WDATA  input  CW  table data
- Q  output  [0:N-1]  registered stage pattern
- POS  output  PW  registered position index
- C  output  [0:CW-1]  character for the current position
- WRAP  output  1  registered one-cycle pulse on wrap-around

Behaviour:
- Reset (async, RST=1):
  - POS=0, Q=1 followed by zeros (ring start), mode register=0, WRAP=0.
  - Table restored to defaults: entries 0..8 = "NickWantz" (0x4E,0x69,0x63,0x6B,0x57,0x61,0x6E,0x74,0x7A); entries >= 9 = 0x20.
- State limit: L = N (ring) or 2N (Johnson). POS is always < L.
- Q is a function of POS and the mode, registered together with POS:
  - Ring: Q[POS]=1, all other bits 0.
  - Johnson, POS=k <= N: Q[0..k-1]=1, rest 0 (POS 0 = all zeros).
  - Johnson, POS=N+k: Q[0..k-1]=0, rest 1.
- Per-edge priority when not in reset: mode change > LOAD > EN step > hold.
  - Mode change (MODE differs from the registered mode): register MODE, POS=0, Q = start pattern of the new mode (Johnson start = all zeros). EN and LOAD are ignored that cycle.
  - LOAD: POS=LOAD_POS if LOAD_POS < L, otherwise POS=0. Q follows. WRAP=0.
  - EN, DIR=0: POS = (POS==L-1) ? 0 : POS+1.
  - EN, DIR=1: POS = (POS==0) ? L-1 : POS-1.
  - Neither: hold.
- WRAP: 1 for exactly the cycle after an EN step that crosses L-1→0 (forward) or 0→L-1 (reverse); otherwise 0.
- C is combinational from registered state, so it changes in the same cycle as Q:
  - Ring: C = table[POS].
  - Johnson: C = table[POS mod N].
- Table writes:
  - WE=1 with WADDR < N writes at the CLK edge; WADDR >= N is ignored.
  - Write to the currently displayed entry: C shows the new value in the cycle after the edge.
  - A write in the same edge as a step: C shows the new value if the new POS maps to WADDR.
  - No write-through forwarding.
- Reset mid-operation: all state and the table return to reset values immediately (asynchronous).

Decomposition:
- Package pattern_pkg: mode encoding (MODE_RING=0, MODE_JOHNSON=1), default character constant array "NickWantz", space fill 0x20, function pos_to_pattern(pos, mode, n).
- One sub-module, char_table: N x CW register file with async reset-to-default, one write port, one combinational read port.

Test Plan:
- Reset, then EN=1, DIR=0, MODE=0 for 9 edges → Q runs 100000000…000000001; C runs N,i,c,k,W,a,n,t,z; WRAP=1 only after the 9th edge (POS 8→0).
- MODE=0, DIR=1, EN=1 from POS=0 → POS=8, Q=000000001, C='z', WRAP=1 on that cycle only.
- MODE→1, then 18 forward steps → Q goes 000000000, 100000000, …, 111111111, 011111111, …, 000000001, then back to 000000000; C at POS 10 = 'i'; WRAP pulses after step 18.
- LOAD=1, LOAD_POS=5 with EN=1 (ring) → POS=5, C='a', no step. LOAD_POS=12 in ring mode → POS=0.
- WE=1, WADDR=3, WDATA=0x21 while POS=3 → C='k' this cycle, '!' next cycle. WADDR=9 is ignored.
- RST asserted mid-sequence at POS=6 after a table write → Q=100000000, C='N', WRAP=0 asynchronously; written entry reverted to default.
